// File: rtl/mem_filter_pkt_assembler_pkg.sv
// Shared definitions for the filter-memory packet assembler: field widths,
// NoC packet field offsets, the assembler state type and the packet packer.
package mem_pkt_pkg;

   localparam int WIDTH_DATA     = 8;
   localparam int WIDTH_ADDR     = 12;
   localparam int WIDTH_DEST     = 4;
   localparam int WIDTH_DATATYPE = 2;
   localparam int LANES          = 4;
   localparam int WIDTH_COUNT    = 3;
   localparam int WIDTH_LANES    = LANES * WIDTH_DATA;
   localparam int WIDTH_PKT      = 64;

   // Idle cycles in COLLECT before a partial packet is pushed out
   // (only used when the timeout feature is built in).
   localparam int TIMEOUT        = 16;

   // Packet field positions (LSB of each field); bits [42:32] are reserved zero.
   localparam int PKT_DEST_LSB   = 60;
   localparam int PKT_TYPE_LSB   = 58;
   localparam int PKT_ADDR_LSB   = 46;
   localparam int PKT_COUNT_LSB  = 43;
   localparam int PKT_LANES_LSB  = 0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      SEND    = 2'd2
   } state_t;

   // Builds a NoC packet from its header fields and the lane payload.
   function automatic logic [WIDTH_PKT-1:0] pack_pkt(
      input logic [WIDTH_DEST-1:0]     dest,
      input logic [WIDTH_DATATYPE-1:0] ptype,
      input logic [WIDTH_ADDR-1:0]     addr,
      input logic [WIDTH_COUNT-1:0]    count,
      input logic [WIDTH_LANES-1:0]    lanes
   );
      logic [WIDTH_PKT-1:0] p;
      p = '0;
      p[PKT_DEST_LSB  +: WIDTH_DEST]     = dest;
      p[PKT_TYPE_LSB  +: WIDTH_DATATYPE] = ptype;
      p[PKT_ADDR_LSB  +: WIDTH_ADDR]     = addr;
      p[PKT_COUNT_LSB +: WIDTH_COUNT]    = count;
      p[PKT_LANES_LSB +: WIDTH_LANES]    = lanes;
      return p;
   endfunction

endpackage

// File: rtl/mem_filter_pkt_assembler_if.sv
// Word-in / packet-out bus of the packet assembler. The master side is the
// environment (filter memory upstream, router downstream); the slave side is
// the assembler itself.
interface mem_filter_pkt_assembler_if;
   import mem_pkt_pkg::*;

   logic                      in_valid;
   logic                      in_ready;
   logic [WIDTH_ADDR-1:0]     in_addr;
   logic [WIDTH_DATA-1:0]     in_data;
   logic [WIDTH_DEST-1:0]     in_dest;
   logic [WIDTH_DATATYPE-1:0] in_datatype;
   logic                      flush;
   logic                      pkt_valid;
   logic                      pkt_ready;
   logic [WIDTH_PKT-1:0]      pkt;
   logic                      busy;

   modport master (
      output in_valid, in_addr, in_data, in_dest, in_datatype, flush, pkt_ready,
      input  in_ready, pkt_valid, pkt, busy
   );

   modport slave (
      input  in_valid, in_addr, in_data, in_dest, in_datatype, flush, pkt_ready,
      output in_ready, pkt_valid, pkt, busy
   );

endinterface

// File: rtl/mem_filter_pkt_assembler_timer.sv
// Idle counter for the packet assembler. Counts consecutive enabled cycles
// since the last clear and flags expiry on the TIMEOUT-th such cycle.
// Only compiled when MEM_PKT_TIMEOUT_EN is defined.
`ifdef MEM_PKT_TIMEOUT_EN
module mem_pkt_timer
   import mem_pkt_pkg::*;
#(
   parameter int LIMIT = TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

   logic [CW-1:0] cnt_q;
   logic          at_limit;

   assign at_limit = (cnt_q == CW'(LIMIT - 1));
   assign expired  = enable & at_limit;

   // Count idle cycles, holding at the limit until the owner clears us
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable && !at_limit) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule
`endif

// File: rtl/mem_filter_pkt_assembler.sv
// Packs up to four address-consecutive filter bytes sharing one destination
// and type into a single 64-bit NoC packet. A partial packet leaves when a
// non-consecutive word arrives, on flush, or (with MEM_PKT_TIMEOUT_EN defined)
// after TIMEOUT idle cycles in COLLECT.
module mem_filter_pkt_assembler (
   input logic                      clk,
   input logic                      rst_n,
   mem_filter_pkt_assembler_if.slave bus
);
   import mem_pkt_pkg::*;

   state_t                    state_q, state_d;
   logic [WIDTH_ADDR-1:0]     base_addr_q;
   logic [WIDTH_DEST-1:0]     dest_q;
   logic [WIDTH_DATATYPE-1:0] type_q;
   logic [WIDTH_COUNT-1:0]    count_q, count_d;
   logic [WIDTH_LANES-1:0]    lanes_q, lanes_d;
   logic [WIDTH_PKT-1:0]      pkt_q, pkt_d;
   logic                      load_hdr;
   logic                      in_ready;
   logic                      match;
   logic                      accept;
   logic                      timeout_hit;
   logic [WIDTH_ADDR:0]       next_addr;

   // One extra address bit means base+count past 0xFFF can never equal a
   // 12-bit input address, so packets never wrap around the address space.
   assign next_addr = {1'b0, base_addr_q} + {{(WIDTH_ADDR + 1 - WIDTH_COUNT){1'b0}}, count_q};
   assign match     = (next_addr == {1'b0, bus.in_addr})
                   && (bus.in_dest == dest_q)
                   && (bus.in_datatype == type_q);
   assign accept    = bus.in_valid & in_ready;

`ifdef MEM_PKT_TIMEOUT_EN
   logic timer_clear;
   logic timer_enable;

   assign timer_enable = (state_q == COLLECT);
   assign timer_clear  = accept | (state_q != COLLECT);

   mem_pkt_timer #(.LIMIT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .expired (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state, lane update and packet build; in_ready is decoded here too
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      lanes_d  = lanes_q;
      pkt_d    = pkt_q;
      in_ready = 1'b0;
      load_hdr = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               load_hdr = 1'b1;
               lanes_d  = {{(WIDTH_LANES - WIDTH_DATA){1'b0}}, bus.in_data};
               count_d  = WIDTH_COUNT'(1);
               state_d  = COLLECT;
            end
         end
         COLLECT: begin
            in_ready = match & ~bus.flush;
            if (bus.flush) begin
               state_d = SEND;
               pkt_d   = pack_pkt(dest_q, type_q, base_addr_q, count_q, lanes_q);
            end else if (bus.in_valid && match) begin
               for (int i = 0; i < LANES; i++) begin
                  if (count_q[1:0] == i[1:0]) begin
                     lanes_d[i*WIDTH_DATA +: WIDTH_DATA] = bus.in_data;
                  end
               end
               count_d = count_q + WIDTH_COUNT'(1);
               if (count_q == WIDTH_COUNT'(LANES - 1)) begin
                  state_d = SEND;
                  pkt_d   = pack_pkt(dest_q, type_q, base_addr_q, count_d, lanes_d);
               end
            end else if (bus.in_valid || timeout_hit) begin
               state_d = SEND;
               pkt_d   = pack_pkt(dest_q, type_q, base_addr_q, count_q, lanes_q);
            end
         end
         SEND: begin
            if (bus.pkt_ready) begin
               state_d = IDLE;
               count_d = '0;
               lanes_d = '0;
               pkt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
            lanes_d = '0;
            pkt_d   = '0;
         end
      endcase
   end

   // State, lane and packet registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         lanes_q <= '0;
         pkt_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         lanes_q <= lanes_d;
         pkt_q   <= pkt_d;
      end
   end

   // Header of the packet under construction, captured on the first word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_addr_q <= '0;
         dest_q      <= '0;
         type_q      <= '0;
      end else if (load_hdr) begin
         base_addr_q <= bus.in_addr;
         dest_q      <= bus.in_dest;
         type_q      <= bus.in_datatype;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.pkt_valid = (state_q == SEND);
   assign bus.pkt       = pkt_q;
   assign bus.busy      = (state_q != IDLE);

endmodule
